// File: rtl/motor_ramp_pkg.sv
// Shared widths, channel state encoding and command clamping for the motor ramp scheduler.
package motor_ramp_pkg;

    localparam int SPD_W   = 9;
    localparam int MAG_MAX = 255;

    typedef enum logic [1:0] {
        HOLD,
        RAMP,
        DEAD
    } ch_state_e;

    // -256 has no positive counterpart, so it is folded onto -255 to keep speeds symmetric.
    function automatic logic [SPD_W-1:0] clamp_speed(input logic [SPD_W-1:0] s);
        logic [SPD_W-1:0] most_neg;
        most_neg = {1'b1, {(SPD_W-1){1'b0}}};
        return (s == most_neg) ? SPD_W'(-MAG_MAX) : s;
    endfunction

endpackage

// File: rtl/ramp_step_unit.sv
// Combinational single-step of a live speed toward its target, braking to zero first on a sign reversal.
module ramp_step_unit
    import motor_ramp_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic signed [SPD_W-1:0] live,
    input  logic signed [SPD_W-1:0] target,
    output logic signed [SPD_W-1:0] next_live,
    output logic                    hit_zero_on_reversal
);

    localparam logic signed [SPD_W:0] STEP_S = (SPD_W+1)'(STEP);

    logic signed [SPD_W:0] live_x;
    logic signed [SPD_W:0] target_x;
    logic signed [SPD_W:0] diff;
    logic signed [SPD_W:0] mag;
    logic signed [SPD_W:0] result;
    logic                  reversal;

    always_comb begin
        live_x   = {live[SPD_W-1], live};
        target_x = {target[SPD_W-1], target};
        diff     = target_x - live_x;
        mag      = live_x[SPD_W] ? -live_x : live_x;
        reversal = ((live_x > 0) && (target_x < 0)) || ((live_x < 0) && (target_x > 0));
        result   = target_x;
        if (reversal) begin
            if (mag <= STEP_S)
                result = '0;
            else
                result = live_x[SPD_W] ? (live_x + STEP_S) : (live_x - STEP_S);
        end else if (diff > STEP_S) begin
            result = live_x + STEP_S;
        end else if (diff < -STEP_S) begin
            result = live_x - STEP_S;
        end
        next_live            = result[SPD_W-1:0];
        hit_zero_on_reversal = reversal && (result == '0);
    end

endmodule

// File: rtl/motor_ramp_sched.sv
// Per-channel speed ramp scheduler feeding PWM timers; one shared step unit is swept across channels each tick.
// Optional build macro MOTOR_RAMP_WDOG_EN adds a command watchdog (WDOG_TICKS parameter, wdog_trip output).
module motor_ramp_sched
    import motor_ramp_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int STEP       = 4,
    parameter int TICK_DIV   = 2500,
    parameter int DEAD_TICKS = 8
`ifdef MOTOR_RAMP_WDOG_EN
    ,
    parameter int WDOG_TICKS = 400
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [CHW-1:0]         cmd_ch,
    input  logic [SPD_W-1:0]       cmd_speed,
    input  logic                   cmd_en,
    output logic [SPD_W*NCH-1:0]   speed_out,
    output logic [NCH-1:0]         en_out,
    output logic [NCH-1:0]         busy
`ifdef MOTOR_RAMP_WDOG_EN
    ,
    output logic                   wdog_trip
`endif
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [TW-1:0]           tick_cnt_reg;
    logic                    sweep_active_reg;
    logic [IW-1:0]           sweep_idx_reg;
    logic signed [SPD_W-1:0] live_reg   [NCH];
    logic signed [SPD_W-1:0] target_reg [NCH];
    ch_state_e               state_reg  [NCH];
    logic [DW-1:0]           dead_reg   [NCH];
    logic [NCH-1:0]          en_reg;

    logic tick_wrap;
    logic cmd_accept;
    logic cmd_hit;
    logic wdog_fire;

    assign tick_wrap  = (tick_cnt_reg == TW'(TICK_DIV - 1));
    assign cmd_ready  = !sweep_active_reg;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign cmd_hit    = cmd_accept && (32'(cmd_ch) < NCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg     <= '0;
            sweep_active_reg <= 1'b0;
            sweep_idx_reg    <= '0;
        end else begin
            tick_cnt_reg <= tick_wrap ? '0 : tick_cnt_reg + TW'(1);
            if (tick_wrap) begin
                sweep_active_reg <= 1'b1;
                sweep_idx_reg    <= '0;
            end else if (sweep_active_reg) begin
                if (sweep_idx_reg == IW'(NCH - 1))
                    sweep_active_reg <= 1'b0;
                sweep_idx_reg <= sweep_idx_reg + IW'(1);
            end
        end
    end

    // Select the channel owning the current sweep slot for the shared step unit.
    logic signed [SPD_W-1:0] slot_live, slot_target, slot_live_next, step_live;
    ch_state_e               slot_state, slot_state_next;
    logic [DW-1:0]           slot_dead, slot_dead_next;
    logic                    step_hit_zero;

    always_comb begin
        slot_live   = live_reg[0];
        slot_target = target_reg[0];
        slot_state  = state_reg[0];
        slot_dead   = dead_reg[0];
        for (int i = 1; i < NCH; i++) begin
            if (sweep_idx_reg == IW'(i)) begin
                slot_live   = live_reg[i];
                slot_target = target_reg[i];
                slot_state  = state_reg[i];
                slot_dead   = dead_reg[i];
            end
        end
    end

    ramp_step_unit #(
        .STEP (STEP)
    ) u_step (
        .live                 (slot_live),
        .target               (slot_target),
        .next_live            (step_live),
        .hit_zero_on_reversal (step_hit_zero)
    );

    always_comb begin
        slot_state_next = slot_state;
        slot_live_next  = slot_live;
        slot_dead_next  = slot_dead;
        case (slot_state)
            DEAD: begin
                slot_dead_next = (slot_dead == '0) ? '0 : slot_dead - DW'(1);
                if (slot_dead <= DW'(1))
                    slot_state_next = (slot_live == slot_target) ? HOLD : RAMP;
            end
            default: begin
                if (slot_live == slot_target) begin
                    slot_state_next = HOLD;
                end else begin
                    slot_live_next = step_live;
                    if (step_hit_zero) begin
                        slot_state_next = DEAD;
                        slot_dead_next  = DW'(DEAD_TICKS);
                    end else begin
                        slot_state_next = (step_live == slot_target) ? HOLD : RAMP;
                    end
                end
            end
        endcase
    end

    // Commands never coincide with a sweep slot because cmd_ready is low throughout the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg <= '0;
            for (int i = 0; i < NCH; i++) begin
                live_reg[i]   <= '0;
                target_reg[i] <= '0;
                state_reg[i]  <= HOLD;
                dead_reg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cmd_hit && (cmd_ch == CHW'(i))) begin
                    if (!cmd_en) begin
                        en_reg[i]     <= 1'b0;
                        live_reg[i]   <= '0;
                        target_reg[i] <= '0;
                        state_reg[i]  <= HOLD;
                        dead_reg[i]   <= '0;
                    end else begin
                        en_reg[i]     <= 1'b1;
                        target_reg[i] <= clamp_speed(cmd_speed);
                    end
                end else if (sweep_active_reg && (sweep_idx_reg == IW'(i))) begin
                    live_reg[i]  <= slot_live_next;
                    state_reg[i] <= slot_state_next;
                    dead_reg[i]  <= slot_dead_next;
                end else if (wdog_fire) begin
                    target_reg[i] <= '0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_out
        assign speed_out[gi*SPD_W +: SPD_W] = live_reg[gi];
        assign busy[gi] = (live_reg[gi] != target_reg[gi]) || (state_reg[gi] == DEAD);
    end
    assign en_out = en_reg;

`ifdef MOTOR_RAMP_WDOG_EN
    localparam int WW = $clog2(WDOG_TICKS + 1);

    logic [WW-1:0] wdog_cnt_reg;
    logic          wdog_trip_reg;

    // Fires once on the tick that completes WDOG_TICKS idle ticks; re-armed only by a command.
    assign wdog_fire = tick_wrap && !cmd_accept && !wdog_trip_reg
                       && (wdog_cnt_reg == WW'(WDOG_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_reg  <= '0;
            wdog_trip_reg <= 1'b0;
        end else if (cmd_accept) begin
            wdog_cnt_reg  <= '0;
            wdog_trip_reg <= 1'b0;
        end else if (wdog_fire) begin
            wdog_cnt_reg  <= WW'(WDOG_TICKS);
            wdog_trip_reg <= 1'b1;
        end else if (tick_wrap && !wdog_trip_reg) begin
            wdog_cnt_reg <= wdog_cnt_reg + WW'(1);
        end
    end

    assign wdog_trip = wdog_trip_reg;
`else
    assign wdog_fire = 1'b0;
`endif

endmodule
